// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - CPU data-port to APB initiator bridge with registered outputs
// Optional ACCESS-phase wait limit enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [15:0] BASE_HI        = 16'h1000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic [31:0]              addr,
    input  logic [31:0]              wData,
    output logic [31:0]              rData,
    output logic                     ready,
    output logic                     err,
    output logic [31:0]              PADDR,
    output logic                     PWRITE,
    output logic [31:0]              PWDATA,
    output logic                     PENABLE,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [32*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY,
    input  logic [NUM_SLAVES-1:0]    PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [4:0] SLOT_LIMIT = 5'(NUM_SLAVES);

    state_t                  state, state_next;
    logic [31:0]             rdata_next, paddr_next, pwdata_next, sel_rdata;
    logic                    ready_next, err_next, pwrite_next, penable_next;
    logic [NUM_SLAVES-1:0]   psel_next, slot_onehot;
    logic                    hit, sel_ready, sel_err;

    assign hit = (addr[31:16] == BASE_HI) && ({1'b0, addr[15:12]} < SLOT_LIMIT);

    // The registered one-hot PSEL doubles as the response mux select during ACCESS.
    assign sel_ready = |(PREADY & PSEL);
    assign sel_err   = |(PSLVERR & PSEL);

    always_comb begin
        slot_onehot = '0;
        sel_rdata   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slot_onehot[i] = (addr[15:12] == 4'(i));
            if (PSEL[i]) sel_rdata = sel_rdata | PRDATA[32*i +: 32];
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 32) ? 5 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt, wait_next;
    logic          timed_out;

    // Compared one below the limit so the bus is held for exactly TIMEOUT_CYCLES ACCESS cycles.
    assign timed_out = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= '0;
        else       wait_cnt <= wait_next;
    end
`endif

    always_comb begin
        state_next   = state;
        rdata_next   = rData;
        ready_next   = 1'b0;
        err_next     = err;
        paddr_next   = PADDR;
        pwrite_next  = PWRITE;
        pwdata_next  = PWDATA;
        penable_next = PENABLE;
        psel_next    = PSEL;
`ifdef APB_TIMEOUT_EN
        wait_next    = wait_cnt;
`endif
        case (state)
            IDLE: begin
                err_next = 1'b0;
                if (req) begin
                    paddr_next  = addr;
                    pwrite_next = we;
                    pwdata_next = wData;
                    if (hit) begin
                        psel_next  = slot_onehot;
                        state_next = SETUP;
                    end else begin
                        err_next   = 1'b1;
                        rdata_next = '0;
                        ready_next = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            SETUP: begin
                penable_next = 1'b1;
`ifdef APB_TIMEOUT_EN
                wait_next    = '0;
`endif
                state_next   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    rdata_next   = PWRITE ? 32'd0 : sel_rdata;
                    err_next     = sel_err;
                    psel_next    = '0;
                    penable_next = 1'b0;
                    ready_next   = 1'b1;
                    state_next   = DONE;
                end
`ifdef APB_TIMEOUT_EN
                else if (timed_out) begin
                    rdata_next   = '0;
                    err_next     = 1'b1;
                    psel_next    = '0;
                    penable_next = 1'b0;
                    ready_next   = 1'b1;
                    state_next   = DONE;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
`endif
            end
            DONE: begin
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rData   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PENABLE <= 1'b0;
            PSEL    <= '0;
        end else begin
            state   <= state_next;
            rData   <= rdata_next;
            ready   <= ready_next;
            err     <= err_next;
            PADDR   <= paddr_next;
            PWRITE  <= pwrite_next;
            PWDATA  <= pwdata_next;
            PENABLE <= penable_next;
            PSEL    <= psel_next;
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed-vector bench for apb_master_bridge
module tb_apb_master_bridge;
    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            reset, req, we;
    logic [31:0]     addr, wData, rData, PADDR, PWDATA;
    logic            ready, err, PWRITE, PENABLE;
    logic [NS-1:0]   PSEL;
    logic [NS-1:0]   PREADY  = '0;
    logic [NS-1:0]   PSLVERR = '0;
    logic [32*NS-1:0] PRDATA = {32'hA3A3_0003, 32'h1234_5678, 32'hDEAD_BEEF, 32'h5A5A_0000};

    int n_checks = 0;
    int n_fail   = 0;
    int wait_states = 0;
    int acc_cnt = 0;
    bit slverr_en = 1'b0;

    int            x_cycles, x_pen;
    bit            x_done;
    logic [NS-1:0] x_psel_or, x_setup_psel;
    logic          x_setup_pen;
    logic [31:0]   x_setup_pwdata, x_setup_paddr;

    always #5 clk = ~clk;

    apb_master_bridge #(.NUM_SLAVES(NS)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wData(wData),
        .rData(rData), .ready(ready), .err(err), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Responder: selected slot ready after wait_states ACCESS cycles; unselected slots
    // assert ready/error as distractors.
    always @(negedge clk) begin
        if (PENABLE && PSEL != '0) acc_cnt = acc_cnt + 1;
        else                       acc_cnt = 0;
        PREADY  = (acc_cnt > wait_states) ? PSEL : ~PSEL;
        PSLVERR = slverr_en ? PSEL : ~PSEL;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the bridge idle; returns at the negedge where ready is seen.
    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; addr = a; wData = d;
        x_cycles = 1; x_pen = 0; x_psel_or = '0; x_done = 1'b0;
        while (!x_done && x_cycles < 150) begin
            @(negedge clk);
            x_cycles++;
            if (x_cycles == 2) begin
                x_setup_psel   = PSEL;
                x_setup_pen    = PENABLE;
                x_setup_pwdata = PWDATA;
                x_setup_paddr  = PADDR;
                addr  = ~a;
                wData = ~d;
            end
            if (PENABLE) x_pen++;
            x_psel_or = x_psel_or | PSEL;
            if (ready) x_done = 1'b1;
        end
        if (!x_done) check("xfer_bound_ready", {31'd0, ready}, 32'd1);
        req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wData = '0;
        #12;
        check("rst_rData",   rData,            32'd0);
        check("rst_ready",   {31'd0, ready},   32'd0);
        check("rst_err",     {31'd0, err},     32'd0);
        check("rst_PADDR",   PADDR,            32'd0);
        check("rst_PWRITE",  {31'd0, PWRITE},  32'd0);
        check("rst_PWDATA",  PWDATA,           32'd0);
        check("rst_PENABLE", {31'd0, PENABLE}, 32'd0);
        check("rst_PSEL",    {28'd0, PSEL},    32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // Zero-wait write to slot 0
        run_xfer(1'b1, 32'h1000_0004, 32'hCAFE_F00D);
        check("wr_setup_psel",   {28'd0, x_setup_psel},  32'h1);
        check("wr_setup_pen",    {31'd0, x_setup_pen},   32'd0);
        check("wr_setup_pwdata", x_setup_pwdata,         32'hCAFE_F00D);
        check("wr_setup_paddr",  x_setup_paddr,          32'h1000_0004);
        check("wr_pen_cycles",   32'(x_pen),             32'd1);
        check("wr_cycles",       32'(x_cycles),          32'd4);
        check("wr_err",          {31'd0, err},           32'd0);
        check("wr_pwrite",       {31'd0, PWRITE},        32'd1);
        check("wr_pwdata_hold",  PWDATA,                 32'hCAFE_F00D);
        @(negedge clk);
        check("wr_ready_after",  {31'd0, ready},         32'd0);

        // Read slot 2 with two wait states
        wait_states = 2;
        run_xfer(1'b0, 32'h1000_2010, 32'h0);
        check("rd2_setup_psel", {28'd0, x_setup_psel}, 32'h4);
        check("rd2_pen_cycles", 32'(x_pen),            32'd3);
        check("rd2_cycles",     32'(x_cycles),         32'd6);
        check("rd2_rData",      rData,                 32'h1234_5678);
        check("rd2_err",        {31'd0, err},          32'd0);
        check("rd2_paddr",      PADDR,                 32'h1000_2010);
        wait_states = 0;
        @(negedge clk);

        // Decode miss outside the window
        run_xfer(1'b0, 32'h2000_0000, 32'h0);
        check("miss1_cycles", 32'(x_cycles),      32'd2);
        check("miss1_psel",   {28'd0, x_psel_or}, 32'd0);
        check("miss1_err",    {31'd0, err},       32'd1);
        check("miss1_rData",  rData,              32'd0);
        @(negedge clk);

        // Slave error on slot 1
        slverr_en = 1'b1;
        run_xfer(1'b0, 32'h1000_1008, 32'h0);
        check("slverr_err",   {31'd0, err}, 32'd1);
        check("slverr_rData", rData,        32'hDEAD_BEEF);
        slverr_en = 1'b0;
        @(negedge clk);
        check("slverr_err_after",   {31'd0, err},   32'd0);
        check("slverr_ready_after", {31'd0, ready}, 32'd0);
        check("rData_hold_idle",    rData,          32'hDEAD_BEEF);

        // Slot number beyond NUM_SLAVES inside the window
        run_xfer(1'b0, 32'h1000_5000, 32'h0);
        check("miss2_cycles", 32'(x_cycles),      32'd2);
        check("miss2_psel",   {28'd0, x_psel_or}, 32'd0);
        check("miss2_err",    {31'd0, err},       32'd1);
        check("miss2_rData",  rData,              32'd0);
        @(negedge clk);

        run_xfer(1'b0, 32'h1000_0000, 32'h0);
        check("rd0_rData", rData, 32'h5A5A_0000);
        @(negedge clk);

        // A write must clear rData
        run_xfer(1'b1, 32'h1000_3FFC, 32'h0BAD_0BAD);
        check("wr3_setup_psel", {28'd0, x_setup_psel}, 32'h8);
        check("wr3_rData",      rData,                 32'd0);
        check("wr3_err",        {31'd0, err},          32'd0);
        @(negedge clk);

        wait_states = 100000;
`ifdef APB_TIMEOUT_EN
        run_xfer(1'b0, 32'h1000_3000, 32'h0);
        check("to_pen_cycles", 32'(x_pen),    32'd16);
        check("to_cycles",     32'(x_cycles), 32'd19);
        check("to_err",        {31'd0, err},  32'd1);
        check("to_rData",      rData,         32'd0);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h1000_3000;
        repeat (3) @(negedge clk);
`else
        req = 1'b1; we = 1'b0; addr = 32'h1000_3000;
        x_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) x_done = 1'b1;
        end
        check("stuck_ready_seen", {31'd0, x_done}, 32'd0);
`endif
        check("stuck_psel", {28'd0, PSEL},    32'h8);
        check("stuck_pen",  {31'd0, PENABLE}, 32'd1);

        // Asynchronous reset in ACCESS
        #2 reset = 1'b1;
        #1;
        check("rstacc_psel",  {28'd0, PSEL},    32'd0);
        check("rstacc_pen",   {31'd0, PENABLE}, 32'd0);
        check("rstacc_ready", {31'd0, ready},   32'd0);
        req = 1'b0;
        wait_states = 0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        run_xfer(1'b0, 32'h1000_0000, 32'h0);
        check("post_rst_cycles", 32'(x_cycles), 32'd4);
        check("post_rst_rData",  rData,         32'h5A5A_0000);
        check("post_rst_err",    {31'd0, err},  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
